// File: rtl/ib_lut_load_sched.sv
// Load/lookup sequencer for one single-port IB LUT bank: streams a full table in, then serves lookups.
// Optional feature macro IB_LUT_HOTSWAP_EN: serve lookups during a reload, with reads taking priority.
module ib_lut_load_sched #(
   parameter int QUAN_SIZE     = 3,
   parameter int PAGE_NUM      = 16,
   parameter int ADDR_BITWIDTH = 4
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     load_start_i,
   input  logic [QUAN_SIZE-1:0]     wr_data_i,
   input  logic                     wr_valid_i,
   output logic                     wr_ready_o,
   input  logic [ADDR_BITWIDTH-1:0] rd_addr_i,
   input  logic                     rd_valid_i,
   output logic                     rd_ready_o,
   output logic [QUAN_SIZE-1:0]     rd_data_o,
   output logic                     rd_data_valid_o,
   output logic                     lut_valid_o,
   output logic                     load_done_o,
   output logic [ADDR_BITWIDTH-1:0] mem_addr_o,
   output logic [QUAN_SIZE-1:0]     mem_wdata_o,
   output logic                     mem_we_o,
   input  logic [QUAN_SIZE-1:0]     mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   // Table length is matched explicitly so PAGE_NUM below 2**ADDR_BITWIDTH still terminates.
   localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(PAGE_NUM - 1);

`ifdef IB_LUT_HOTSWAP_EN
   localparam bit HOTSWAP = 1'b1;
`else
   localparam bit HOTSWAP = 1'b0;
`endif

   state_e                   state_q, state_d;
   logic [ADDR_BITWIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic                     lut_valid_q, lut_valid_d;
   logic                     load_done_q, load_done_d;
   logic [QUAN_SIZE-1:0]     rd_data_q, rd_data_d;
   logic                     rd_data_valid_q, rd_data_valid_d;

   logic                     wr_ready;
   logic                     rd_accept;
   logic                     wr_beat;
   logic                     last_beat;

   // NOTE: sequential state uses non-blocking assignments only; the comb processes compute the _d values.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         wr_cnt_q        <= '0;
         lut_valid_q     <= 1'b0;
         load_done_q     <= 1'b0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         wr_cnt_q        <= wr_cnt_d;
         lut_valid_q     <= lut_valid_d;
         load_done_q     <= load_done_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      if (load_start_i) begin
         state_d  = ST_LOAD;
         wr_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (wr_beat) begin
                  if (last_beat) begin
                     state_d  = ST_ACTIVE;
                     wr_cnt_d = '0;
                  end else begin
                     wr_cnt_d = wr_cnt_q + ADDR_BITWIDTH'(1);
                  end
               end
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Output process: a load start always wins over a same-cycle read or write beat.
   always_comb begin
      wr_ready  = 1'b0;
      rd_accept = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            rd_accept = HOTSWAP & rd_valid_i & ~load_start_i;
            wr_ready  = ~load_start_i & ~rd_accept;
         end
         ST_ACTIVE: rd_accept = rd_valid_i & ~load_start_i;
         default: begin
            wr_ready  = 1'b0;
            rd_accept = 1'b0;
         end
      endcase

      wr_beat   = wr_valid_i & wr_ready;
      last_beat = wr_beat & (wr_cnt_q == LAST_IDX);

      mem_we_o    = wr_beat;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (wr_beat) begin
         mem_addr_o  = wr_cnt_q;
         mem_wdata_o = wr_data_i;
      end else if (rd_accept) begin
         mem_addr_o  = rd_addr_i;
      end
   end

   always_comb begin
      lut_valid_d = lut_valid_q;
      if (load_start_i) begin
         lut_valid_d = HOTSWAP & lut_valid_q;
      end else if (last_beat) begin
         lut_valid_d = 1'b1;
      end

      load_done_d     = last_beat;
      rd_data_valid_d = rd_accept;
      rd_data_d       = rd_accept ? mem_rdata_i : rd_data_q;
   end

   assign wr_ready_o      = wr_ready;
   assign rd_ready_o      = rd_accept;
   assign rd_data_o       = rd_data_q;
   assign rd_data_valid_o = rd_data_valid_q;
   assign lut_valid_o     = lut_valid_q;
   assign load_done_o     = load_done_q;

endmodule
